rt_ibex_window_ctrl: RTL and testbench

- Sequencer directly upstream of the windowed register file.
- Turns interrupt-entry and mret-exit requests from the controller into the file's increment_ptr/decrement_ptr/save_csr strobes.
- Captures the windowed mcause/mepc back for CSR restore.
- When all windows are in use, falls back to software stacking ("overflow" levels). Tracks nesting depth and overflow depth so exits unwind in the correct order.

---
 rtl/rt_ibex_window_pkg.sv | 25 ++
 rtl/rt_ibex_sat_counter.sv | 43 ++++
 rtl/rt_ibex_window_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rt_ibex_window_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_ibex_window_pkg.sv
// Shared types and sizing helpers for the register-window sequencer.
package rt_ibex_window_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        E_INC  = 3'd1,
        E_SAVE = 3'd2,
        E_OVF  = 3'd3,
        X_RST  = 3'd4,
        X_DEC  = 3'd5,
        X_OVF  = 3'd6,
        X_ERR  = 3'd7
    } window_ctrl_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned NumRegisterWindowsDefault = 4;
    localparam int unsigned MaxOverflowDefault        = 15;
    localparam int unsigned DepthWidth    = cnt_width(NumRegisterWindowsDefault - 1);
    localparam int unsigned OverflowWidth = cnt_width(MaxOverflowDefault);

endpackage

// File: rtl/rt_ibex_sat_counter.sv
// Up/down counter that holds at Max on increment and at zero on decrement.
module rt_ibex_sat_counter
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned Width = OverflowWidth,
    parameter int unsigned Max   = MaxOverflowDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             sat_o,
    output logic             zero_o
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] cnt_reg;
    logic [Width-1:0] cnt_next;

    assign sat_o  = (cnt_reg == MaxVal);
    assign zero_o = (cnt_reg == '0);
    assign cnt_o  = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc_i && !dec_i && !sat_o) begin
            cnt_next = cnt_reg + Width'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_next = cnt_reg - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/rt_ibex_window_ctrl.sv
// Sequences interrupt entry / mret exit into register-window strobes, with software-stack fallback.
// Optional build macro RT_IBEX_WINDOW_CHECK_EN: cross-checks window_full_i against the internal depth.
module rt_ibex_window_ctrl
    import rt_ibex_window_pkg::*;
#(
    parameter int unsigned NumRegisterWindows = 4,
    parameter int unsigned MaxOverflow        = 15,
    parameter int unsigned DataWidth          = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  entry_req_i,
    output logic                                  entry_gnt_o,
    output logic                                  entry_windowed_o,
    input  logic                                  exit_req_i,
    output logic                                  exit_gnt_o,
    output logic                                  exit_windowed_o,
    input  logic                                  window_full_i,
    input  logic [DataWidth-1:0]                  mcause_win_i,
    input  logic [DataWidth-1:0]                  mepc_win_i,
    output logic                                  increment_ptr_o,
    output logic                                  decrement_ptr_o,
    output logic                                  save_csr_o,
    output logic                                  csr_restore_o,
    output logic [DataWidth-1:0]                  mcause_restore_o,
    output logic [DataWidth-1:0]                  mepc_restore_o,
    output logic [$clog2(NumRegisterWindows)-1:0] depth_o,
    output logic [$clog2(MaxOverflow+1)-1:0]      overflow_cnt_o,
    output logic                                  err_o
);

    localparam int unsigned DepthW = $clog2(NumRegisterWindows);
    localparam int unsigned OvfW   = $clog2(MaxOverflow + 1);

    window_ctrl_state_e state_reg, state_next;

    logic                 err_reg, err_next;
    logic [DataWidth-1:0] mcause_reg, mepc_reg;
    logic                 capture;
    logic                 depth_inc, depth_dec, depth_sat, depth_zero;
    logic                 ovf_inc, ovf_dec, ovf_sat, ovf_zero;
    logic                 last_window;
    logic                 full_mismatch;

    rt_ibex_sat_counter #(
        .Width (DepthW),
        .Max   (NumRegisterWindows - 1)
    ) u_depth_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (depth_inc),
        .dec_i  (depth_dec),
        .cnt_o  (depth_o),
        .sat_o  (depth_sat),
        .zero_o (depth_zero)
    );

    rt_ibex_sat_counter #(
        .Width (OvfW),
        .Max   (MaxOverflow)
    ) u_ovf_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ovf_inc),
        .dec_i  (ovf_dec),
        .cnt_o  (overflow_cnt_o),
        .sat_o  (ovf_sat),
        .zero_o (ovf_zero)
    );

`ifdef RT_IBEX_WINDOW_CHECK_EN
    // Trust our own depth; a disagreeing register file is flagged while idle.
    assign last_window   = depth_sat;
    assign full_mismatch = (state_reg == IDLE) && (window_full_i != depth_sat);
`else
    logic unused_depth_sat;
    assign unused_depth_sat = depth_sat;
    assign last_window      = window_full_i;
    assign full_mismatch    = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        capture          = 1'b0;
        entry_gnt_o      = 1'b0;
        entry_windowed_o = 1'b0;
        exit_gnt_o       = 1'b0;
        exit_windowed_o  = 1'b0;
        increment_ptr_o  = 1'b0;
        decrement_ptr_o  = 1'b0;
        save_csr_o       = 1'b0;
        csr_restore_o    = 1'b0;
        depth_inc        = 1'b0;
        depth_dec        = 1'b0;
        ovf_inc          = 1'b0;
        ovf_dec          = 1'b0;
        err_next         = err_reg | full_mismatch;

        case (state_reg)
            IDLE: begin
                if (entry_req_i) begin
                    state_next = (ovf_zero && !last_window) ? E_INC : E_OVF;
                end else if (exit_req_i) begin
                    if (!ovf_zero) begin
                        state_next = X_OVF;
                    end else if (!depth_zero) begin
                        state_next = X_RST;
                        capture    = 1'b1;
                    end else begin
                        state_next = X_ERR;
                    end
                end
            end
            E_INC: begin
                increment_ptr_o = 1'b1;
                state_next      = E_SAVE;
            end
            // Saving after the increment lands mcause/mepc in the new window's slot.
            E_SAVE: begin
                save_csr_o       = 1'b1;
                entry_gnt_o      = 1'b1;
                entry_windowed_o = 1'b1;
                depth_inc        = 1'b1;
                state_next       = IDLE;
            end
            E_OVF: begin
                entry_gnt_o = 1'b1;
                ovf_inc     = 1'b1;
                err_next    = err_next | ovf_sat;
                state_next  = IDLE;
            end
            X_RST: begin
                csr_restore_o = 1'b1;
                state_next    = X_DEC;
            end
            X_DEC: begin
                decrement_ptr_o = 1'b1;
                exit_gnt_o      = 1'b1;
                exit_windowed_o = 1'b1;
                depth_dec       = 1'b1;
                state_next      = IDLE;
            end
            X_OVF: begin
                exit_gnt_o = 1'b1;
                ovf_dec    = 1'b1;
                state_next = IDLE;
            end
            X_ERR: begin
                exit_gnt_o = 1'b1;
                err_next   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        err_o = err_reg | (state_reg == X_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            err_reg    <= 1'b0;
            mcause_reg <= '0;
            mepc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (capture) begin
                mcause_reg <= mcause_win_i;
                mepc_reg   <= mepc_win_i;
            end
        end
    end

    assign mcause_restore_o = mcause_reg;
    assign mepc_restore_o   = mepc_reg;

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
// Self-checking bench for rt_ibex_window_ctrl: directed scenarios plus a randomized run against a nesting model.
module tb_rt_ibex_window_ctrl;

    localparam int NW = 4;
    localparam int MO = 15;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          entry_req_i = 1'b0;
    logic          exit_req_i = 1'b0;
    logic          window_full_i = 1'b0;
    logic [DW-1:0] mcause_win_i = '0;
    logic [DW-1:0] mepc_win_i = '0;
    logic          entry_gnt_o, entry_windowed_o, exit_gnt_o, exit_windowed_o;
    logic          increment_ptr_o, decrement_ptr_o, save_csr_o, csr_restore_o;
    logic [DW-1:0] mcause_restore_o, mepc_restore_o;
    logic [1:0]    depth_o;
    logic [3:0]    overflow_cnt_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    rt_ibex_window_ctrl #(
        .NumRegisterWindows (NW),
        .MaxOverflow        (MO),
        .DataWidth          (DW)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .entry_req_i      (entry_req_i),
        .entry_gnt_o      (entry_gnt_o),
        .entry_windowed_o (entry_windowed_o),
        .exit_req_i       (exit_req_i),
        .exit_gnt_o       (exit_gnt_o),
        .exit_windowed_o  (exit_windowed_o),
        .window_full_i    (window_full_i),
        .mcause_win_i     (mcause_win_i),
        .mepc_win_i       (mepc_win_i),
        .increment_ptr_o  (increment_ptr_o),
        .decrement_ptr_o  (decrement_ptr_o),
        .save_csr_o       (save_csr_o),
        .csr_restore_o    (csr_restore_o),
        .mcause_restore_o (mcause_restore_o),
        .mepc_restore_o   (mepc_restore_o),
        .depth_o          (depth_o),
        .overflow_cnt_o   (overflow_cnt_o),
        .err_o            (err_o)
    );

    wire [8:0] flags = {entry_gnt_o, entry_windowed_o, exit_gnt_o, exit_windowed_o,
                        increment_ptr_o, decrement_ptr_o, save_csr_o, csr_restore_o, err_o};

    typedef struct {
        int          lat;
        bit          ent;
        bit          win;
        int          n_inc;
        int          n_dec;
        int          n_save;
        int          n_rst;
        int          inc_cyc;
        logic [31:0] mc;
        logic [31:0] mp;
        bit          excl_bad;
    } obs_t;

    int n_cmp = 0;
    int n_fail = 0;
    int n_txn = 0;
    int m_depth, m_ovf;
    bit m_err;

    task automatic apply_reset();
        rst_ni = 1'b0;
        entry_req_i = 1'b0;
        exit_req_i = 1'b0;
        window_full_i = 1'b0;
        mcause_win_i = '0;
        mepc_win_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        m_depth = 0;
        m_ovf = 0;
        m_err = 1'b0;
    endtask

    // Drives one request until its grant (bounded), then lets the FSM settle back to idle.
    task automatic do_txn(input bit ent, input bit ext, input logic [31:0] mc, input logic [31:0] mp,
                          input bit full, output obs_t o);
        o = '{lat: -1, ent: 0, win: 0, n_inc: 0, n_dec: 0, n_save: 0, n_rst: 0, inc_cyc: -1,
              mc: '0, mp: '0, excl_bad: 0};
        window_full_i = full;
        mcause_win_i = mc;
        mepc_win_i = mp;
        entry_req_i = ent;
        exit_req_i = ext;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 1) begin
                mcause_win_i = ~mc;
                mepc_win_i = ~mp;
            end
            if (increment_ptr_o) begin
                o.n_inc++;
                if (o.inc_cyc < 0) o.inc_cyc = c;
            end
            if (decrement_ptr_o) o.n_dec++;
            if (save_csr_o) o.n_save++;
            if (csr_restore_o) begin
                o.n_rst++;
                o.mc = mcause_restore_o;
                o.mp = mepc_restore_o;
            end
            if ((int'(increment_ptr_o) + int'(decrement_ptr_o) + int'(save_csr_o) + int'(csr_restore_o)) > 1)
                o.excl_bad = 1'b1;
            if (entry_gnt_o || exit_gnt_o) begin
                o.lat = c;
                o.ent = entry_gnt_o;
                o.win = entry_gnt_o ? entry_windowed_o : exit_windowed_o;
                break;
            end
        end
        entry_req_i = 1'b0;
        exit_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_txn++;
        $display("txn %0d: entry_req=%0b exit_req=%0b full=%0b -> lat=%0d entry=%0b windowed=%0b depth=%0d ovf=%0d err=%0b",
                 n_txn, ent, ext, full, o.lat, o.ent, o.win, depth_o, overflow_cnt_o, err_o);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (flags !== 9'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000000", flags); end
        n_cmp++; if (depth_o !== 2'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", depth_o); end
        n_cmp++; if (overflow_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt_o); end
        n_cmp++; if (mcause_restore_o !== 32'h0) begin n_fail++; $display("FAIL reset_mcause: got %h want 0", mcause_restore_o); end
        n_cmp++; if (mepc_restore_o !== 32'h0) begin n_fail++; $display("FAIL reset_mepc: got %h want 0", mepc_restore_o); end
    endtask

    task automatic test_entry();
        obs_t o;
        apply_reset();
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        n_cmp++; if (o.lat !== 2) begin n_fail++; $display("FAIL entry_latency: got %0d want 2", o.lat); end
        n_cmp++; if (o.inc_cyc !== 1) begin n_fail++; $display("FAIL entry_inc_cycle: got %0d want 1", o.inc_cyc); end
        n_cmp++; if (o.n_inc !== 1 || o.n_save !== 1 || o.n_dec !== 0 || o.n_rst !== 0) begin
            n_fail++; $display("FAIL entry_strobes: got inc=%0d save=%0d dec=%0d rst=%0d want 1 1 0 0", o.n_inc, o.n_save, o.n_dec, o.n_rst); end
        n_cmp++; if (o.ent !== 1'b1 || o.win !== 1'b1) begin n_fail++; $display("FAIL entry_windowed: got ent=%0b win=%0b want 1 1", o.ent, o.win); end
        n_cmp++; if (depth_o !== 2'd1) begin n_fail++; $display("FAIL entry_depth: got %0d want 1", depth_o); end
    endtask

    task automatic test_exit_windowed();
        obs_t o;
        do_txn(1'b0, 1'b1, 32'h8000_0007, 32'h0000_1234, 1'b0, o);
        n_cmp++; if (o.lat !== 2) begin n_fail++; $display("FAIL exit_latency: got %0d want 2", o.lat); end
        n_cmp++; if (o.mc !== 32'h8000_0007 || o.mp !== 32'h0000_1234) begin
            n_fail++; $display("FAIL exit_restore_data: got %h/%h want 80000007/00001234", o.mc, o.mp); end
        n_cmp++; if (o.n_rst !== 1 || o.n_dec !== 1 || o.n_inc !== 0 || o.n_save !== 0) begin
            n_fail++; $display("FAIL exit_strobes: got rst=%0d dec=%0d inc=%0d save=%0d want 1 1 0 0", o.n_rst, o.n_dec, o.n_inc, o.n_save); end
        n_cmp++; if (o.ent !== 1'b0 || o.win !== 1'b1) begin n_fail++; $display("FAIL exit_windowed: got ent=%0b win=%0b want 0 1", o.ent, o.win); end
        n_cmp++; if (depth_o !== 2'd0) begin n_fail++; $display("FAIL exit_depth: got %0d want 0", depth_o); end
    endtask

    task automatic test_overflow();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 3; i++) do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, o);
        n_cmp++; if (o.ent !== 1'b1 || o.win !== 1'b0 || o.lat !== 1) begin
            n_fail++; $display("FAIL ovf_entry: got ent=%0b win=%0b lat=%0d want 1 0 1", o.ent, o.win, o.lat); end
        n_cmp++; if (overflow_cnt_o !== 4'd1 || depth_o !== 2'd3) begin
            n_fail++; $display("FAIL ovf_entry_counts: got ovf=%0d depth=%0d want 1 3", overflow_cnt_o, depth_o); end
        n_cmp++; if (o.n_inc + o.n_dec + o.n_save + o.n_rst !== 0) begin
            n_fail++; $display("FAIL ovf_entry_strobes: got %0d strobes want 0", o.n_inc + o.n_dec + o.n_save + o.n_rst); end
        do_txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, o);
        n_cmp++; if (o.ent !== 1'b0 || o.win !== 1'b0 || overflow_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL ovf_exit: got ent=%0b win=%0b ovf=%0d want 0 0 0", o.ent, o.win, overflow_cnt_o); end
        n_cmp++; if (o.n_inc + o.n_dec + o.n_save + o.n_rst !== 0) begin
            n_fail++; $display("FAIL ovf_exit_strobes: got %0d strobes want 0", o.n_inc + o.n_dec + o.n_save + o.n_rst); end
        do_txn(1'b0, 1'b1, 32'hCAFE_0003, 32'h0000_4000, 1'b1, o);
        n_cmp++; if (o.win !== 1'b1 || o.n_rst !== 1 || o.mc !== 32'hCAFE_0003 || depth_o !== 2'd2) begin
            n_fail++; $display("FAIL ovf_then_window_exit: got win=%0b rst=%0d mcause=%h depth=%0d want 1 1 cafe0003 2", o.win, o.n_rst, o.mc, depth_o); end
    endtask

    task automatic test_priority();
        obs_t o;
        apply_reset();
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        do_txn(1'b1, 1'b1, 32'h0, 32'h0, 1'b0, o);
        n_cmp++; if (o.ent !== 1'b1 || o.win !== 1'b1 || depth_o !== 2'd2) begin
            n_fail++; $display("FAIL priority: got ent=%0b win=%0b depth=%0d want 1 1 2", o.ent, o.win, depth_o); end
    endtask

    task automatic test_underflow();
        obs_t o;
        apply_reset();
        do_txn(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, o);
        n_cmp++; if (o.ent !== 1'b0 || o.win !== 1'b0 || o.lat !== 1 || o.n_dec !== 0) begin
            n_fail++; $display("FAIL underflow_exit: got ent=%0b win=%0b lat=%0d dec=%0d want 0 0 1 0", o.ent, o.win, o.lat, o.n_dec); end
        n_cmp++; if (err_o !== 1'b1 || depth_o !== 2'd0) begin
            n_fail++; $display("FAIL underflow_err: got err=%0b depth=%0d want 1 0", err_o, depth_o); end
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        n_cmp++; if (err_o !== 1'b1 || depth_o !== 2'd1) begin
            n_fail++; $display("FAIL err_sticky: got err=%0b depth=%0d want 1 1", err_o, depth_o); end
    endtask

    task automatic test_saturation();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 3; i++) do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        for (int i = 0; i < MO; i++) do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, o);
        n_cmp++; if (overflow_cnt_o !== 4'(MO) || err_o !== 1'b0) begin
            n_fail++; $display("FAIL sat_reach_max: got ovf=%0d err=%0b want 15 0", overflow_cnt_o, err_o); end
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, o);
        n_cmp++; if (overflow_cnt_o !== 4'(MO) || err_o !== 1'b1 || o.win !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: got ovf=%0d err=%0b win=%0b want 15 1 0", overflow_cnt_o, err_o, o.win); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        apply_reset();
        entry_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++; if (increment_ptr_o !== 1'b1) begin n_fail++; $display("FAIL mid_inc_seen: got %0b want 1", increment_ptr_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (flags !== 9'b0 || depth_o !== 2'd0 || overflow_cnt_o !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got flags=%b depth=%0d ovf=%0d want 0 0 0", flags, depth_o, overflow_cnt_o); end
        entry_req_i = 1'b0;
        #2;
        rst_ni = 1'b1;
        m_depth = 0; m_ovf = 0; m_err = 1'b0;
        @(posedge clk_i);
        #1;
        n_cmp++; if (flags !== 9'b0 || depth_o !== 2'd0) begin
            n_fail++; $display("FAIL mid_after_release: got flags=%b depth=%0d want 0 0", flags, depth_o); end
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, o);
        n_cmp++; if (o.lat !== 2 || o.inc_cyc !== 1 || o.n_save !== 1 || o.win !== 1'b1 || depth_o !== 2'd1) begin
            n_fail++; $display("FAIL mid_reentry: got lat=%0d inc_cyc=%0d save=%0d win=%0b depth=%0d want 2 1 1 1 1",
                               o.lat, o.inc_cyc, o.n_save, o.win, depth_o); end
    endtask

    // The model tracks nesting as two integers: windows held and software-stacked levels.
    task automatic test_random();
        obs_t o;
        bit ent, ext, full, e_win;
        int e_lat, e_inc, e_dec, e_save, e_rst, pct;
        logic [31:0] mc, mp;
        apply_reset();
        for (int t = 0; t < 300; t++) begin
            pct = ((t / 40) % 2 == 0) ? 70 : 30;
            ent = ($urandom_range(99) < pct);
            ext = ent ? ($urandom_range(3) == 0) : 1'b1;
            mc = $urandom;
            mp = $urandom;
            full = (m_depth == NW - 1);
            e_win = 0; e_lat = 1; e_inc = 0; e_dec = 0; e_save = 0; e_rst = 0;
            if (ent) begin
                if (m_ovf == 0 && !full) begin
                    e_win = 1; e_lat = 2; e_inc = 1; e_save = 1; m_depth++;
                end else if (m_ovf == MO) begin
                    m_err = 1;
                end else begin
                    m_ovf++;
                end
            end else if (m_ovf > 0) begin
                m_ovf--;
            end else if (m_depth > 0) begin
                e_win = 1; e_lat = 2; e_dec = 1; e_rst = 1; m_depth--;
            end else begin
                m_err = 1;
            end
            do_txn(ent, ext, mc, mp, full, o);
            n_cmp++; if (o.lat !== e_lat || o.ent !== ent || o.win !== e_win) begin
                n_fail++; $display("FAIL rnd_grant t=%0d: got lat=%0d ent=%0b win=%0b want %0d %0b %0b", t, o.lat, o.ent, o.win, e_lat, ent, e_win); end
            n_cmp++; if (o.n_inc !== e_inc || o.n_dec !== e_dec || o.n_save !== e_save || o.n_rst !== e_rst || o.excl_bad) begin
                n_fail++; $display("FAIL rnd_strobes t=%0d: got %0d/%0d/%0d/%0d excl_bad=%0b want %0d/%0d/%0d/%0d 0",
                                   t, o.n_inc, o.n_dec, o.n_save, o.n_rst, o.excl_bad, e_inc, e_dec, e_save, e_rst); end
            if (e_rst == 1) begin
                n_cmp++; if (o.mc !== mc || o.mp !== mp) begin
                    n_fail++; $display("FAIL rnd_restore t=%0d: got %h/%h want %h/%h", t, o.mc, o.mp, mc, mp); end
            end
            n_cmp++; if (depth_o !== 2'(m_depth) || overflow_cnt_o !== 4'(m_ovf) || err_o !== m_err) begin
                n_fail++; $display("FAIL rnd_state t=%0d: got depth=%0d ovf=%0d err=%0b want %0d %0d %0b",
                                   t, depth_o, overflow_cnt_o, err_o, m_depth, m_ovf, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit_windowed();
        test_overflow();
        test_priority();
        test_underflow();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
